// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master for the cu_buff_eeprom control unit.
// Shifts one byte out on MOSI, MSB first, and captures one byte from MISO.
// The control unit owns nCS, so this block only drives SCK and MOSI.
// Every output comes straight from a register, so no input reaches an output
// through combinational logic.
module spi_byte_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_data,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              spi_busy,
  output logic              spi_done,
  output logic [DATA_W-1:0] rx_data
);

  // Terminal count of the half-period counter.
  localparam logic [7:0] HLAST    = 8'(CLK_DIV - 1);
  // Index of the last bit. bitCnt is 3 bits wide because DATA_W is fixed at 8.
  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  state_t            state_q;
  logic [7:0]        hCnt_q;
  logic [2:0]        bitCnt_q;
  logic [DATA_W-1:0] shReg_q;
  logic [DATA_W-1:0] rxSh_q;
  logic              sck_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rxData_q;

  // Single-process transfer FSM.
  // It times both SCK half-periods and registers every SPI output. The
  // transmit register shifts left after each SCK high phase, so its bit
  // DATA_W-2 always holds the next bit to place on MOSI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hCnt_q   <= '0;
      bitCnt_q <= '0;
      shReg_q  <= '0;
      rxSh_q   <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rxData_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          sck_q  <= 1'b0;
          if (load_data) begin
            shReg_q  <= data_in;
            mosi_q   <= data_in[DATA_W-1];
            busy_q   <= 1'b1;
            hCnt_q   <= '0;
            bitCnt_q <= '0;
            state_q  <= LOW;
          end
        end
        LOW: begin
          if (hCnt_q == HLAST) begin
            sck_q   <= 1'b1;
            rxSh_q  <= (rxSh_q << 1) | {{(DATA_W-1){1'b0}}, miso};
            hCnt_q  <= '0;
            state_q <= HIGH;
          end else begin
            hCnt_q <= hCnt_q + 8'd1;
          end
        end
        HIGH: begin
          if (hCnt_q == HLAST) begin
            sck_q  <= 1'b0;
            hCnt_q <= '0;
            if (bitCnt_q == BIT_LAST) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              rxData_q <= rxSh_q;
              mosi_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              mosi_q   <= shReg_q[DATA_W-2];
              shReg_q  <= shReg_q << 1;
              bitCnt_q <= bitCnt_q + 3'd1;
              state_q  <= LOW;
            end
          end else begin
            hCnt_q <= hCnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign spi_busy = busy_q;
  assign spi_done = done_q;
  assign rx_data  = rxData_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Randomised scoreboard testbench for spi_byte_master.
// The stimulus side queues the byte it expects on MOSI and on rx_data for
// every accepted load. A monitor collects the MOSI bits seen at each SCK rise
// and compares them against the queue on every spi_done pulse.
module tb_spi_byte_master;

  localparam int CLK_DIV   = 4;
  localparam int BUSY_CLKS = 16 * CLK_DIV;
  localparam int WAIT_MAX  = 2000;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_data;
  logic [7:0] data_in;
  logic       miso;
  logic       sck;
  logic       mosi;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] rx_data;

  logic       loopMode;
  logic [7:0] slaveByte;
  int         slaveIdx;
  logic       misoDrv;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  spi_byte_master #(.CLK_DIV(CLK_DIV), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_data(load_data),
    .data_in  (data_in),
    .miso     (miso),
    .sck      (sck),
    .mosi     (mosi),
    .spi_busy (spi_busy),
    .spi_done (spi_done),
    .rx_data  (rx_data)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // MISO is either looped back from MOSI or driven by the slave model.
  assign misoDrv = slaveByte[slaveIdx];
  assign miso    = loopMode ? mosi : misoDrv;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Slave model: present MSB when a transfer starts, advance on each SCK fall.
  task automatic slaveLoop();
    logic lastBusy = 1'b0;
    forever begin
      @(posedge spi_busy or negedge sck);
      if (spi_busy && !lastBusy) slaveIdx = 7;
      else if (slaveIdx > 0) slaveIdx--;
      lastBusy = spi_busy;
    end
  endtask

  // Monitor: sample on negedge, check each spi_done against the scoreboard.
  task automatic monitorLoop();
    int         busyCnt  = 0;
    int         riseCnt  = 0;
    logic [7:0] txCap    = '0;
    logic       sckPrev  = 1'b0;
    logic       donePrev = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busyCnt  = 0;
        riseCnt  = 0;
        txCap    = '0;
        sckPrev  = 1'b0;
        donePrev = 1'b0;
      end else begin
        if (spi_busy) busyCnt++;
        if (sck && !sckPrev) begin
          txCap = {txCap[6:0], mosi};
          riseCnt++;
        end
        sckPrev = sck;
        if (spi_done) begin
          checkOutput("done_pulse_width", {31'd0, donePrev}, 0);
          checkOutput("done_has_pending", {31'd0, expQ.size() != 0}, 1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
            checkOutput("mosi_bits", {24'd0, txCap}, {24'd0, e.tx});
            checkOutput("sck_rises", riseCnt, 8);
            checkOutput("busy_clocks", busyCnt, BUSY_CLKS);
            checkOutput("busy_low_at_done", {31'd0, spi_busy}, 0);
          end
          busyCnt = 0;
          riseCnt = 0;
          txCap   = '0;
        end
        donePrev = spi_done;
      end
    end
  endtask

  // Issue a load at a negedge when the DUT is known to accept it.
  task automatic applyStimulus(input logic [7:0] tx, input logic loop,
                               input logic [7:0] mByte);
    exp_t e;
    e.tx      = tx;
    e.rx      = loop ? tx : mByte;
    data_in   = tx;
    load_data = 1'b1;
    loopMode  = loop;
    slaveByte = mByte;
    expQ.push_back(e);
    @(negedge clk);
    load_data = 1'b0;
    data_in   = 8'($urandom);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < WAIT_MAX && (expQ.size() != 0 || spi_busy); i++) @(negedge clk);
    if (expQ.size() != 0 || spi_busy) checkOutput("idle_timeout", expQ.size(), 0);
  endtask

  task automatic waitDone();
    int i;
    for (i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (spi_done) break;
    end
    if (i == WAIT_MAX) checkOutput("done_timeout", {31'd0, spi_done}, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sck"}, {31'd0, sck}, 0);
    checkOutput({tag, "_mosi"}, {31'd0, mosi}, 0);
    checkOutput({tag, "_busy"}, {31'd0, spi_busy}, 0);
    checkOutput({tag, "_done"}, {31'd0, spi_done}, 0);
    checkOutput({tag, "_rx"}, {24'd0, rx_data}, 0);
  endtask

  initial begin
    logic [7:0] tx;
    logic [7:0] mb;
    logic       lp;
    rst       = 1'b1;
    load_data = 1'b0;
    data_in   = '0;
    loopMode  = 1'b0;
    slaveByte = '0;
    slaveIdx  = 7;
    fork
      slaveLoop();
      monitorLoop();
    join_none

    // Reset values, then a quiet idle period.
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checkResetOutputs("idle50");

    // Loopback of 0xA5.
    applyStimulus(8'hA5, 1'b1, 8'h00);
    waitIdle();

    // MISO tied high with zero data, then tied low with all-ones data.
    applyStimulus(8'h00, 1'b0, 8'hFF);
    waitIdle();
    applyStimulus(8'hFF, 1'b0, 8'h00);
    waitIdle();

    // A load during busy clock 20 must be ignored.
    applyStimulus(8'h81, 1'b1, 8'h00);
    repeat (19) @(negedge clk);
    data_in   = 8'h3C;
    load_data = 1'b1;
    @(negedge clk);
    load_data = 1'b0;
    waitIdle();
    repeat (BUSY_CLKS + 8) @(negedge clk);
    checkOutput("ignored_load_busy", {31'd0, spi_busy}, 0);

    // A load in the spi_done cycle restarts after a single idle clock.
    applyStimulus(8'h12, 1'b0, 8'hC9);
    waitDone();
    applyStimulus(8'h34, 1'b0, 8'h6E);
    checkOutput("b2b_restart", {31'd0, spi_busy}, 1);
    waitIdle();

    // Asynchronous reset at busy clock 20 aborts the transfer.
    applyStimulus(8'hC3, 1'b1, 8'h00);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetOutputs("abort");
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 8'h00);
    waitIdle();

    // Random transfers with random gaps, including back-to-back loads.
    applyStimulus(8'($urandom), 1'($urandom), 8'($urandom));
    for (int n = 0; n < 12; n++) begin
      tx = 8'($urandom);
      mb = 8'($urandom);
      lp = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        waitDone();
      end else begin
        waitIdle();
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      applyStimulus(tx, lp, mb);
    end
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
